count_seq_ctrl: RTL and testbench

//  Sequencer for the 8-bit loadable up-counter: drives its load/enable/data and watches its

---
 rtl/count_seq_ctrl.sv | 92 +++++++++
 tb/tb_count_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// Command sequencer for an external 8-bit loadable up-counter: loads start, counts to end,
// repeats the pass cmd_repeat extra times, then pulses done. Supports pause and abort.
module count_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_start,
  input  logic [WIDTH-1:0]    cmd_end,
  input  logic [REPEAT_W-1:0] cmd_repeat,
  input  logic                pause,
  input  logic                abort,
  input  logic [WIDTH-1:0]    count,
  output logic                cnt_load,
  output logic                cnt_enable,
  output logic [WIDTH-1:0]    cnt_data,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    start_q, end_q;
  logic [REPEAT_W-1:0] rep_left;
  logic                at_end;

  assign at_end = (count == end_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      rep_left <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        start_q  <= cmd_start;
        end_q    <= cmd_end;
        rep_left <= cmd_repeat;
      end
      if (state_q == RUN && !abort && at_end && rep_left != '0)
        rep_left <= rep_left - 1'b1;
    end
  end

  // abort wins over the terminal-count decision and kills load/enable in the same cycle
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) state_d = LOAD;
      LOAD: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_load   = 1'b1;
          cnt_enable = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_enable = !pause && !at_end;
          if (at_end) state_d = (rep_left == '0) ? DONE : LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_data  = start_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: behavioural counter, directed vector table, randomized
// trace checks against a pass/offset reference model, and abort/reset/ignore sequences.
module tb_count_seq_ctrl;
  localparam int W  = 8;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset, cmd_valid, pause, abort;
  logic [W-1:0]  cmd_start, cmd_end, count, cnt_data;
  logic [RW-1:0] cmd_repeat;
  logic          cmd_ready, cnt_load, cnt_enable, busy, done, aborted;

  int checks = 0;
  int passed = 0;

  count_seq_ctrl #(.WIDTH(W), .REPEAT_W(RW)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_repeat(cmd_repeat),
    .pause(pause), .abort(abort), .count(count),
    .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_data(cnt_data),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  // the external counter: load has priority over enable, no reset from the sequencer
  always_ff @(posedge clock) begin
    if (cnt_load)        count <= cnt_data;
    else if (cnt_enable) count <= count + 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pack(input bit rdy, bsy, dn, ld, en, input logic [7:0] d);
    return int'({rdy, bsy, dn, ld, en, d});
  endfunction

  function automatic int outs();
    return int'({cmd_ready, busy, done, cnt_load, cnt_enable, cnt_data});
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  // Issue a command; the accepting edge is T, and the cycle just after it is cyc=1.
  task automatic issue(input logic [7:0] s, e, input logic [3:0] r);
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_start = s; cmd_end = e; cmd_repeat = r;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic exec(input logic [7:0] s, e, input logic [3:0] r, input int pcnt, plen,
                      output int dcyc, output int ndone, output int nload);
    int rem = plen;
    bit fin = 1'b0;
    dcyc = -1; ndone = 0; nload = 0;
    issue(s, e, r);
    for (int cyc = 1; cyc < 6000 && !fin; cyc++) begin
      if (cyc > 1) begin @(posedge clock); #1; end
      pause = busy && !cnt_load && (int'(count) == pcnt) && rem > 0;
      if (pause) rem--;
      @(negedge clock);
      if (cnt_load) nload++;
      if (done) begin ndone++; dcyc = cyc; end
      if (cmd_ready) fin = 1'b1;
    end
    pause = 1'b0;
    chk("exec_finished", int'(fin), 1);
  endtask

  // Reference: each pass is one load cycle then offsets 0..N of the counter,
  // where an offset below N is held for every paused cycle.
  task automatic rand_trace(input logic [7:0] s, e, input logic [3:0] r);
    int exp_o[$];
    int exp_c[$];
    bit pz[$];
    int n = (int'(e) - int'(s) + 256) % 256;
    for (int p = 0; p <= int'(r); p++) begin
      exp_o.push_back(pack(0, 1, 0, 1, 1, s)); exp_c.push_back(-1); pz.push_back($urandom_range(0, 1) == 1);
      for (int k = 0; ; ) begin
        bit pb = ($urandom_range(0, 3) == 0);
        pz.push_back(pb);
        if (k == n) begin
          exp_o.push_back(pack(0, 1, 0, 0, 0, s)); exp_c.push_back((int'(s) + n) % 256);
          break;
        end
        exp_o.push_back(pack(0, 1, 0, 0, !pb, s)); exp_c.push_back((int'(s) + k) % 256);
        if (!pb) k++;
      end
    end
    exp_o.push_back(pack(0, 1, 1, 0, 0, s)); exp_c.push_back((int'(s) + n) % 256); pz.push_back(1'b0);
    exp_o.push_back(pack(1, 0, 0, 0, 0, s)); exp_c.push_back((int'(s) + n) % 256); pz.push_back(1'b0);
    issue(s, e, r);
    for (int i = 0; i < exp_o.size(); i++) begin
      if (i > 0) begin @(posedge clock); #1; end
      pause = pz[i];
      @(negedge clock);
      chk("trace_outputs", outs(), exp_o[i]);
      if (exp_c[i] >= 0) chk("trace_count", int'(count), exp_c[i]);
    end
    pause = 1'b0;
  endtask

  typedef struct {
    logic [7:0] s, e;
    logic [3:0] r;
    int         pcnt, plen, exp_done;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int dcyc, ndone, nload, seen;
    logic [7:0] rs;

    tbl[0] = '{8'd10,  8'd15, 4'd0, -1, 0, 8};
    tbl[1] = '{8'd250, 8'd3,  4'd0, -1, 0, 12};
    tbl[2] = '{8'd0,   8'd3,  4'd2, -1, 0, 16};
    tbl[3] = '{8'd0,   8'd4,  4'd0,  2, 3, 10};
    tbl[4] = '{8'd5,   8'd5,  4'd0, -1, 0, 3};

    reset = 1'b1; cmd_valid = 1'b1; pause = 1'b0; abort = 1'b0;
    cmd_start = 8'd77; cmd_end = 8'd99; cmd_repeat = 4'd1;
    repeat (3) @(negedge clock);
    chk("reset_outputs", outs(), pack(1, 0, 0, 0, 0, 8'd0));
    chk("reset_aborted", int'(aborted), 0);
    @(posedge clock); #1;
    cmd_valid = 1'b0; reset = 1'b0;

    foreach (tbl[i]) begin
      exec(tbl[i].s, tbl[i].e, tbl[i].r, tbl[i].pcnt, tbl[i].plen, dcyc, ndone, nload);
      chk($sformatf("vec%0d_done_cycle", i), dcyc, tbl[i].exp_done);
      chk($sformatf("vec%0d_done_pulses", i), ndone, 1);
      chk($sformatf("vec%0d_load_pulses", i), nload, int'(tbl[i].r) + 1);
    end

    for (int i = 0; i < 8; i++) begin
      rs = 8'($urandom);
      rand_trace(rs, rs + 8'($urandom_range(0, 40)), 4'($urandom_range(0, 3)));
    end
    rs = 8'($urandom);
    rand_trace(rs, rs - 8'd1, 4'd0);

    // commands presented while busy must not be accepted or relatched
    issue(8'd5, 8'd5, 4'd0);
    cmd_valid = 1'b1; cmd_start = 8'd100; cmd_end = 8'd200; cmd_repeat = 4'd3;
    @(negedge clock);
    chk("ign_load", int'(cnt_load), 1);
    chk("ign_data_load", int'(cnt_data), 5);
    @(posedge clock); #1;
    @(negedge clock);
    chk("ign_data_run", int'(cnt_data), 5);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("ign_done", int'(done), 1);
    repeat (2) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("ign_idle_after", outs(), pack(1, 0, 0, 0, 0, 8'd5));
    end

    // abort while the count is 7
    issue(8'd0, 8'd20, 4'd0);
    for (int i = 0; i < 50 && !(busy && !cnt_load && count == 8'd7); i++) begin
      @(posedge clock); #1;
    end
    chk("abort_reached7", int'(count), 7);
    abort = 1'b1;
    @(negedge clock);
    chk("abort_pulse", int'({aborted, cnt_load, cnt_enable}), 3'b100);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("abort_idle", int'({cmd_ready, busy, aborted, done}), 4'b1000);
    chk("abort_frozen", int'(count == 8'd7 || count == 8'd8), 1);
    seen = 0;
    repeat (25) begin
      @(negedge clock);
      if (done || aborted || busy) seen++;
    end
    chk("abort_no_done", seen, 0);

    // asynchronous reset in the middle of a pass
    issue(8'd0, 8'd200, 4'd1);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("rst_async", outs(), pack(1, 0, 0, 0, 0, 8'd0));
    @(negedge clock);
    chk("rst_mid_run", outs(), pack(1, 0, 0, 0, 0, 8'd0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_held_valid", int'({busy, done, aborted}), 0);
    @(posedge clock); #1;
    reset = 1'b0; cmd_valid = 1'b0;

    exec(8'd5, 8'd5, 4'd0, -1, 0, dcyc, ndone, nload);
    chk("post_rst_done_cycle", dcyc, 3);
    chk("post_rst_done_pulses", ndone, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
